// File: rtl/pcm_output.sv
// pcm_output: rounds/saturates 65-bit overlap-add samples to signed PCM and buffers them in a small FIFO.
// Optional PCM_OUTPUT_CLIP_COUNT_EN adds out_pcm_clipCount, a saturating count of clipped samples.
module pcm_output #(
    parameter int SHIFT      = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [64:0]                 in_pcm_pcmSample,
    input  logic                        in_pcm_valid,
    output logic                        in_pcm_ready,
    output logic signed [OUT_WIDTH-1:0] out_pcm_sample,
    output logic                        out_pcm_valid,
    input  logic                        out_pcm_ready,
    output logic                        out_pcm_clipped,
    output logic                        out_pcm_underrun,
    output logic [31:0]                 out_pcm_sampleCount
`ifdef PCM_OUTPUT_CLIP_COUNT_EN
    ,
    output logic [15:0]                 out_pcm_clipCount
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic signed [65:0] RND     = 66'sd1 <<< (SHIFT - 1);
    localparam logic signed [65:0] SAT_MAX = (66'sd1 <<< (OUT_WIDTH - 1)) - 66'sd1;
    localparam logic signed [65:0] SAT_MIN = -(66'sd1 <<< (OUT_WIDTH - 1));

    typedef enum logic [1:0] {IDLE, STREAM, UNDERRUN} state_t;

    state_t                       state, state_nxt;
    logic [AW-1:0]                wr_ptr, rd_ptr;
    logic [CW-1:0]                count;
    logic signed [OUT_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic signed [65:0]           ext, rounded;
    logic signed [OUT_WIDTH-1:0]  conv;
    logic                         sat, accept, deliver;

    assign in_pcm_ready     = count < CW'(FIFO_DEPTH);
    assign out_pcm_valid    = count != '0;
    assign out_pcm_sample   = mem[rd_ptr];
    assign out_pcm_underrun = state == UNDERRUN;
    assign accept           = in_pcm_valid && in_pcm_ready;
    assign deliver          = out_pcm_valid && out_pcm_ready;

    // round half up, then floor-shift
    assign ext     = $signed({in_pcm_pcmSample[64], in_pcm_pcmSample});
    assign rounded = (ext + RND) >>> SHIFT;
    assign sat     = (rounded > SAT_MAX) || (rounded < SAT_MIN);
    assign conv    = rounded > SAT_MAX ? SAT_MAX[OUT_WIDTH-1:0] :
                     rounded < SAT_MIN ? SAT_MIN[OUT_WIDTH-1:0] : rounded[OUT_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= conv;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            count               <= '0;
            out_pcm_clipped     <= 1'b0;
            out_pcm_sampleCount <= '0;
        end else begin
            state           <= state_nxt;
            out_pcm_clipped <= accept && sat;
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (deliver) begin
                rd_ptr              <= rd_ptr + AW'(1);
                out_pcm_sampleCount <= out_pcm_sampleCount + 32'd1;
            end
            if (accept && !deliver) count <= count + CW'(1);
            else if (deliver && !accept) count <= count - CW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        state_nxt = state == IDLE   ? (accept ? STREAM : IDLE) :
                    state == STREAM ? ((count == '0 && out_pcm_ready && !accept) ? UNDERRUN : STREAM) :
                                      (accept ? STREAM : state);
    end

`ifdef PCM_OUTPUT_CLIP_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) out_pcm_clipCount <= '0;
        else if (accept && sat && out_pcm_clipCount != 16'hFFFF) out_pcm_clipCount <= out_pcm_clipCount + 16'd1;
    end
`endif
endmodule

// File: tb/tb_pcm_output.sv
// tb_pcm_output: vector table, directed corner sequences and a randomized scoreboard run for pcm_output.
module tb_pcm_output;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [64:0]        din = '0;
    logic               in_valid = 1'b0, out_ready = 1'b0;
    logic               in_ready, out_valid, clipped, underrun;
    logic signed [15:0] dout;
    logic [31:0]        scount;
    logic [64:0]        b_din = '0;
    logic               b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic               b_in_ready, b_out_valid, b_clipped, b_underrun;
    logic signed [15:0] b_dout;
    logic [31:0]        b_scount;
`ifdef PCM_OUTPUT_CLIP_COUNT_EN
    logic [15:0]        ccount, b_ccount;
`endif

    pcm_output dut (
        .clk(clk), .reset(reset), .in_pcm_pcmSample(din), .in_pcm_valid(in_valid),
        .in_pcm_ready(in_ready), .out_pcm_sample(dout), .out_pcm_valid(out_valid),
        .out_pcm_ready(out_ready), .out_pcm_clipped(clipped), .out_pcm_underrun(underrun),
        .out_pcm_sampleCount(scount)
`ifdef PCM_OUTPUT_CLIP_COUNT_EN
        , .out_pcm_clipCount(ccount)
`endif
    );

    pcm_output #(.FIFO_DEPTH(2)) dut2 (
        .clk(clk), .reset(reset), .in_pcm_pcmSample(b_din), .in_pcm_valid(b_in_valid),
        .in_pcm_ready(b_in_ready), .out_pcm_sample(b_dout), .out_pcm_valid(b_out_valid),
        .out_pcm_ready(b_out_ready), .out_pcm_clipped(b_clipped), .out_pcm_underrun(b_underrun),
        .out_pcm_sampleCount(b_scount)
`ifdef PCM_OUTPUT_CLIP_COUNT_EN
        , .out_pcm_clipCount(b_ccount)
`endif
    );

    int checks = 0, errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [64:0] din;
        longint      exp;
        bit          clip;
    } vec_t;
    vec_t vecs [10];

    // reference: integer part plus one when the fraction is at least one half, then clamp
    function automatic longint ref_pcm(input logic signed [32:0] ip, input logic [31:0] frac, output bit sat);
        longint r;
        r = longint'(ip) + ((frac >= 32'h8000_0000) ? 1 : 0);
        sat = (r > 32767) || (r < -32768);
        return r > 32767 ? 32767 : (r < -32768 ? -32768 : r);
    endfunction

    initial begin
        vecs[0] = '{65'h0_0000_0001_8000_0000,      2, 1'b0};
        vecs[1] = '{65'h1_FFFF_FFFF_8000_0000,      0, 1'b0};
        vecs[2] = '{65'h0_0001_0000_0000_0000,  32767, 1'b1};
        vecs[3] = '{65'h1_FFFF_0000_0000_0000, -32768, 1'b1};
        vecs[4] = '{65'h0_0000_7FFF_7FFF_FFFF,  32767, 1'b0};
        vecs[5] = '{65'h0_0000_7FFF_8000_0000,  32767, 1'b1};
        vecs[6] = '{65'h1_FFFF_8000_0000_0000, -32768, 1'b0};
        vecs[7] = '{65'h1_FFFF_7FFF_FFFF_FFFF, -32768, 1'b0};
        vecs[8] = '{65'h1_FFFF_7FFF_7FFF_FFFF, -32768, 1'b1};
        vecs[9] = '{65'h0_0000_0000_0000_0000,      0, 1'b0};

        #2;
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);
        check("rst_count", scount, 0);
        check("rst_underrun", underrun, 0);
        check("rst_clipped", clipped, 0);
        @(negedge clk);
        reset = 1'b1;

        // IDLE must not report underrun even when the consumer is waiting
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_underrun", underrun, 0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1; din = vecs[i].din;
            @(negedge clk);
            in_valid = 1'b0;
            check("tbl_valid", out_valid, 1);
            check("tbl_sample", dout, vecs[i].exp);
            check("tbl_clipped", clipped, vecs[i].clip);
        end
`ifdef PCM_OUTPUT_CLIP_COUNT_EN
        check("tbl_clipcount", ccount, 4);
`endif

        // underrun
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; din = {33'sd7, 32'h0};
        @(negedge clk);
        in_valid = 1'b0;
        check("ur_valid", out_valid, 1);
        check("ur_stream", underrun, 0);
        @(negedge clk);
        check("ur_empty", out_valid, 0);
        check("ur_not_yet", underrun, 0);
        @(negedge clk);
        check("ur_set", underrun, 1);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("ur_clear", underrun, 0);
        check("ur_sample", dout, 7);

        // full and backpressure
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("full_ready", in_ready, (k < 4) ? 1 : 0);
            in_valid = 1'b1; din = {33'(k + 1), 32'h0};
        end
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        check("full_ready_hold", in_ready, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("full_sample0", dout, 2);
        for (int k = 2; k <= 4; k++) begin
            check("full_order", dout, k);
            @(negedge clk);
        end
        check("full_drained", out_valid, 0);
        check("full_scount", scount, 4);

        // reset with entries queued
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_scount", scount, 0);
        check("mid_rst_underrun", underrun, 0);
        @(negedge clk);
        reset = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", in_ready, 1);
        @(negedge clk);
        check("mid_rst_idle", underrun, 0);

        // concurrent push/pop on the 2-entry instance
        begin
            int ready_drops = 0, order_errs = 0;
            b_in_valid = 1'b1; b_out_ready = 1'b1;
            for (int i = 0; i <= 100; i++) begin
                b_din = {33'(i), 32'h0};
                @(negedge clk);
                if (!b_in_ready) ready_drops++;
                if (!b_out_valid || b_dout != 16'(i)) order_errs++;
            end
            b_in_valid = 1'b0; b_out_ready = 1'b0;
            check("pp_ready_drops", ready_drops, 0);
            check("pp_order_errs", order_errs, 0);
            check("pp_scount", b_scount, 100);
        end

        // randomized run against the scoreboard
        do_reset();
        begin
            longint q[$];
            bit clip_m = 0;
            int st = 0;
            longint sc_m = 0, cc_m = 0;
            for (int n = 0; n < 600; n++) begin
                bit iv, orr, acc, del, sat;
                int ip;
                logic signed [32:0] h;
                logic [31:0] frac;
                longint r;
                @(negedge clk);
                check("rnd_valid", out_valid, q.size() > 0);
                check("rnd_ready", in_ready, q.size() < 4);
                if (q.size() > 0) check("rnd_sample", dout, q[0]);
                check("rnd_clipped", clipped, clip_m);
                check("rnd_underrun", underrun, st == 2);
                check("rnd_scount", scount, sc_m);
`ifdef PCM_OUTPUT_CLIP_COUNT_EN
                check("rnd_clipcount", ccount, cc_m);
`endif
                iv = ($urandom % 3) != 0;
                orr = $urandom % 2;
                ip = int'($urandom_range(90000)) - 45000;
                if ($urandom % 6 == 0) ip = int'($urandom);
                h = 33'(ip);
                frac = $urandom;
                r = ref_pcm(h, frac, sat);
                acc = iv && q.size() < 4;
                del = orr && q.size() > 0;
                if (st == 0 && acc) st = 1;
                else if (st == 1 && q.size() == 0 && orr && !acc) st = 2;
                else if (st == 2 && acc) st = 1;
                if (del) begin
                    void'(q.pop_front());
                    sc_m++;
                end
                if (acc) q.push_back(r);
                clip_m = acc && sat;
                if (acc && sat && cc_m < 65535) cc_m++;
                in_valid = iv; out_ready = orr; din = {h, frac};
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
